spare_link_prbs_tester: RTL and testbench

Parametrised multi-channel test engine for the single-ended/LVDS spare lines between FPGA#1 and FPGA#2 and the front-panel test connector. Each channel transmits PRBS-7, or loops its input back to its output in LOOP mode. A self-synchronising checker on each channel reports lock state and a saturating error count. The block sits between the IBUFDS/OBUFDS wrappers and the board-level status logic; the checker outputs feed the status LEDs and the I2C register map.

---
 rtl/spare_link_prbs_tester_if.sv | 37 +++
 rtl/spare_link_prbs_tester.sv | 177 +++++++++++++++++
 tb/tb_spare_link_prbs_tester.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/spare_link_prbs_tester_if.sv
// ---------------------------------------------------------------------------
// spare_link_prbs_tester_if
// Groups the lane-level and status signals of the spare-link PRBS tester.
//   rx_in      raw lane inputs from the IBUFDS wrappers (async to clk)
//   tx_out     registered lane outputs to the OBUFDS wrappers
//   mode       per lane: 0 = PRBS generate/check, 1 = LOOP
//   inject     per lane one-cycle pulse that inverts one transmitted bit
//   err_clr    clears every error counter
//   locked     per lane checker lock indication
//   all_locked every lane locked and none in LOOP mode
//   err_cnt    packed saturating error counters, lane i at [i*ERR_W +: ERR_W]
// The master modport is the controlling side (board logic or testbench);
// the slave modport is the tester itself.
// ---------------------------------------------------------------------------
interface spare_link_prbs_tester_if #(
  parameter int N_CHAN = 3,
  parameter int ERR_W  = 16
);
  logic [N_CHAN-1:0]       rx_in;
  logic [N_CHAN-1:0]       tx_out;
  logic [N_CHAN-1:0]       mode;
  logic [N_CHAN-1:0]       inject;
  logic                    err_clr;
  logic [N_CHAN-1:0]       locked;
  logic                    all_locked;
  logic [N_CHAN*ERR_W-1:0] err_cnt;

  modport master (
    output rx_in, mode, inject, err_clr,
    input  tx_out, locked, all_locked, err_cnt
  );

  modport slave (
    input  rx_in, mode, inject, err_clr,
    output tx_out, locked, all_locked, err_cnt
  );
endinterface

// File: rtl/spare_link_prbs_tester.sv
// ---------------------------------------------------------------------------
// spare_link_prbs_tester
// Multi-lane PRBS-7 (x^7+x^6+1) generator and self-synchronising checker for
// the spare lines between the FPGAs and the front-panel test connector.
// Each lane either transmits PRBS-7 or loops its synchronised input back.
// A per-lane checker hunts for lock and counts bit errors once locked.
// Ports:
//   clk    lane bit clock, one bit per cycle
//   rst_n  synchronous active-low reset
//   bus    spare_link_prbs_tester_if slave modport (lanes, controls, status)
// ---------------------------------------------------------------------------
module spare_link_prbs_tester #(
  parameter int N_CHAN      = 3,
  parameter int ERR_W       = 16,
  parameter int LOCK_CNT    = 64,
  parameter int UNLOCK_ERRS = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  spare_link_prbs_tester_if.slave  bus
);

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } chk_state_e;

  localparam logic [7:0] LOCK_CNT_W    = 8'(LOCK_CNT);
  localparam logic [7:0] UNLOCK_ERRS_W = 8'(UNLOCK_ERRS);

  logic [N_CHAN-1:0] sync1_q, sync1_d;
  logic [N_CHAN-1:0] rxs_q, rxs_d;
  logic [N_CHAN-1:0] tx_q, tx_d;
  logic              all_locked_q, all_locked_d;
  logic [6:0]        gen_q [N_CHAN];
  logic [6:0]        gen_d [N_CHAN];
  logic [6:0]        chk_q [N_CHAN];
  logic [6:0]        chk_d [N_CHAN];
  chk_state_e        state_q [N_CHAN];
  chk_state_e        state_d [N_CHAN];
  logic [7:0]        good_q [N_CHAN];
  logic [7:0]        good_d [N_CHAN];
  logic [7:0]        bad_q [N_CHAN];
  logic [7:0]        bad_d [N_CHAN];
  logic [ERR_W-1:0]  err_q [N_CHAN];
  logic [ERR_W-1:0]  err_d [N_CHAN];

  // Next-state logic for every lane: synchroniser, generator, transmit
  // register, self-synchronising checker and the lock state machine.
  always_comb begin
    logic prbs_bit;
    logic pred_bit;
    logic miss;
    logic all_ok;

    sync1_d = bus.rx_in;
    rxs_d   = sync1_q;
    tx_d    = '0;
    all_ok  = 1'b1;

    for (int i = 0; i < N_CHAN; i++) begin
      prbs_bit = gen_q[i][6] ^ gen_q[i][5];
      gen_d[i] = {gen_q[i][5:0], prbs_bit};
      tx_d[i]  = (bus.mode[i] ? rxs_q[i] : prbs_bit) ^ bus.inject[i];

      // The checker predicts each bit from the last seven received ones.
      // An all-zero history would predict 0 forever, so a zero bit on a
      // zero history is treated as a miss to catch stuck-at-0 lines.
      pred_bit = chk_q[i][6] ^ chk_q[i][5];
      miss     = (rxs_q[i] != pred_bit) || ((chk_q[i] == 7'd0) && !rxs_q[i]);
      chk_d[i] = {chk_q[i][5:0], rxs_q[i]};

      state_d[i] = state_q[i];
      good_d[i]  = good_q[i];
      bad_d[i]   = bad_q[i];
      err_d[i]   = err_q[i];

      if (bus.mode[i]) begin
        state_d[i] = HUNT;
        good_d[i]  = '0;
        bad_d[i]   = '0;
      end else begin
        case (state_q[i])
          HUNT: begin
            if (miss) begin
              good_d[i] = '0;
            end else if (good_q[i] + 8'd1 == LOCK_CNT_W) begin
              state_d[i] = LOCKED;
              good_d[i]  = '0;
              bad_d[i]   = '0;
            end else begin
              good_d[i] = good_q[i] + 8'd1;
            end
          end
          LOCKED: begin
            if (miss) begin
              if (err_q[i] != {ERR_W{1'b1}}) begin
                err_d[i] = err_q[i] + 1'b1;
              end
              good_d[i] = '0;
              if (bad_q[i] + 8'd1 == UNLOCK_ERRS_W) begin
                state_d[i] = HUNT;
                bad_d[i]   = '0;
              end else begin
                bad_d[i] = bad_q[i] + 8'd1;
              end
            end else if (good_q[i] + 8'd1 == LOCK_CNT_W) begin
              // A full clean run forgives earlier scattered errors.
              good_d[i] = '0;
              bad_d[i]  = '0;
            end else begin
              good_d[i] = good_q[i] + 8'd1;
            end
          end
          default: begin
            state_d[i] = HUNT;
            good_d[i]  = '0;
            bad_d[i]   = '0;
          end
        endcase
      end

      if (bus.err_clr) begin
        err_d[i] = '0;
      end

      if ((state_d[i] != LOCKED) || bus.mode[i]) begin
        all_ok = 1'b0;
      end
    end

    all_locked_d = all_ok;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q      <= '0;
      rxs_q        <= '0;
      tx_q         <= '0;
      all_locked_q <= 1'b0;
      for (int i = 0; i < N_CHAN; i++) begin
        gen_q[i]   <= 7'h7F;
        chk_q[i]   <= 7'h00;
        state_q[i] <= HUNT;
        good_q[i]  <= '0;
        bad_q[i]   <= '0;
        err_q[i]   <= '0;
      end
    end else begin
      sync1_q      <= sync1_d;
      rxs_q        <= rxs_d;
      tx_q         <= tx_d;
      all_locked_q <= all_locked_d;
      for (int i = 0; i < N_CHAN; i++) begin
        gen_q[i]   <= gen_d[i];
        chk_q[i]   <= chk_d[i];
        state_q[i] <= state_d[i];
        good_q[i]  <= good_d[i];
        bad_q[i]   <= bad_d[i];
        err_q[i]   <= err_d[i];
      end
    end
  end

  // All outputs come straight from flops.
  always_comb begin
    bus.tx_out     = tx_q;
    bus.all_locked = all_locked_q;
    bus.locked     = '0;
    bus.err_cnt    = '0;
    for (int i = 0; i < N_CHAN; i++) begin
      bus.locked[i]                 = (state_q[i] == LOCKED);
      bus.err_cnt[i*ERR_W +: ERR_W] = err_q[i];
    end
  end

endmodule

// File: tb/tb_spare_link_prbs_tester.sv
// ---------------------------------------------------------------------------
// tb_spare_link_prbs_tester
// Exercises a 3-lane, 16-bit-counter tester (dut0) in external loopback and
// a 1-lane, 4-bit-counter tester (dut1) for counter saturation and clear.
// ---------------------------------------------------------------------------
module tb_spare_link_prbs_tester;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  spare_link_prbs_tester_if #(.N_CHAN(3), .ERR_W(16)) bus0 ();
  spare_link_prbs_tester_if #(.N_CHAN(1), .ERR_W(4))  bus1 ();

  // Lane wiring: either external loopback (optionally inverted) or a
  // directly driven pattern.
  logic [2:0] use_drv = 3'b000;
  logic [2:0] rx_drv  = 3'b000;
  logic [2:0] inv0    = 3'b000;
  logic       inv1    = 1'b0;

  assign bus0.rx_in = (use_drv & rx_drv) | (~use_drv & (bus0.tx_out ^ inv0));
  assign bus1.rx_in = bus1.tx_out ^ inv1;

  spare_link_prbs_tester #(
    .N_CHAN(3), .ERR_W(16), .LOCK_CNT(64), .UNLOCK_ERRS(8)
  ) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0.slave)
  );

  spare_link_prbs_tester #(
    .N_CHAN(1), .ERR_W(4), .LOCK_CNT(16), .UNLOCK_ERRS(255)
  ) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_inject = 0;

  function automatic logic [15:0] lane_err(input int i);
    return bus0.err_cnt[i*16 +: 16];
  endfunction

  // PRBS-7 reference: each bit is the XOR of the bits 6 and 7 positions
  // earlier; the seven bits before the first output are all ones.
  function automatic logic prbs_ref(input int k);
    logic hist [$];
    for (int n = 0; n < 7; n++) hist.push_back(1'b1);
    for (int n = 7; n < k + 7; n++) hist.push_back(hist[n-7] ^ hist[n-6]);
    return hist[k+6];
  endfunction

  task automatic test_reset();
    int lock_cycle;
    logic [2:0] exp_tx;
    bus0.mode = 3'b000; bus0.inject = 3'b000; bus0.err_clr = 1'b0;
    bus1.mode = 1'b0;   bus1.inject = 1'b0;   bus1.err_clr = 1'b0;
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++; if (bus0.tx_out !== 3'b000) $display("[TB] FAIL reset_tx got %b want 000", bus0.tx_out); else n_pass++;
    n_checks++; if (bus0.locked !== 3'b000) $display("[TB] FAIL reset_locked got %b want 000", bus0.locked); else n_pass++;
    n_checks++; if (bus0.all_locked !== 1'b0) $display("[TB] FAIL reset_all_locked got %b want 0", bus0.all_locked); else n_pass++;
    n_checks++; if (bus0.err_cnt !== 48'd0) $display("[TB] FAIL reset_err got %h want 0", bus0.err_cnt); else n_pass++;

    rst_n = 1'b1;
    lock_cycle = -1;
    for (int k = 1; k <= 75; k++) begin
      @(negedge clk);
      if (k <= 20) begin
        exp_tx = {3{prbs_ref(k)}};
        n_checks++;
        if (bus0.tx_out !== exp_tx)
          $display("[TB] FAIL prbs_bit%0d got %b want %b", k, bus0.tx_out, exp_tx);
        else n_pass++;
      end
      if (lock_cycle < 0 && bus0.locked === 3'b111) lock_cycle = k;
    end
    n_checks++;
    if (lock_cycle < 0) $display("[TB] FAIL lock_within_75 got %b want 111", bus0.locked); else n_pass++;
    n_checks++; if (bus0.all_locked !== 1'b1) $display("[TB] FAIL all_locked got %b want 1", bus0.all_locked); else n_pass++;
    n_checks++; if (bus1.locked !== 1'b1) $display("[TB] FAIL dut1_lock got %b want 1", bus1.locked); else n_pass++;

    repeat (10000) @(negedge clk);
    n_checks++; if (bus0.err_cnt !== 48'd0) $display("[TB] FAIL clean_run_err got %h want 0", bus0.err_cnt); else n_pass++;
    n_checks++; if (bus0.locked !== 3'b111) $display("[TB] FAIL clean_run_locked got %b want 111", bus0.locked); else n_pass++;
  endtask

  task automatic test_single_inject();
    int count;
    count = $urandom_range(2, 4);
    for (int n = 0; n < count; n++) begin
      bus0.inject = 3'b010;
      @(negedge clk);
      bus0.inject = 3'b000;
      n_inject++;
      repeat ($urandom_range(80, 120)) @(negedge clk);
      if (n == 0) begin
        n_checks++;
        if (lane_err(1) !== 16'd3) $display("[TB] FAIL inject_first got %0d want 3", lane_err(1)); else n_pass++;
      end
      n_checks++;
      if (bus0.locked[1] !== 1'b1) $display("[TB] FAIL inject_lock got %b want 1", bus0.locked[1]); else n_pass++;
    end
    n_checks++;
    if (lane_err(1) !== 16'(3 * n_inject))
      $display("[TB] FAIL inject_total got %0d want %0d", lane_err(1), 3 * n_inject);
    else n_pass++;
    n_checks++;
    if (lane_err(0) !== 16'd0 || lane_err(2) !== 16'd0)
      $display("[TB] FAIL inject_other_lanes got %0d/%0d want 0/0", lane_err(0), lane_err(2));
    else n_pass++;
  endtask

  task automatic test_unlock();
    bit fell;
    int bad_cycles;
    fell = 1'b0;
    inv0[0] = 1'b1;
    for (int k = 0; k < 40 && !fell; k++) begin
      @(negedge clk);
      if (bus0.locked[0] === 1'b0) fell = 1'b1;
    end
    n_checks++; if (!fell) $display("[TB] FAIL unlock_timeout got %b want 0", bus0.locked[0]); else n_pass++;
    n_checks++; if (lane_err(0) !== 16'd8) $display("[TB] FAIL unlock_err got %0d want 8", lane_err(0)); else n_pass++;
    bad_cycles = 0;
    repeat (200) begin
      @(negedge clk);
      if (bus0.locked[0] !== 1'b0 || bus0.all_locked !== 1'b0) bad_cycles++;
    end
    n_checks++; if (bad_cycles !== 0) $display("[TB] FAIL unlock_stays_hunt got %0d want 0 locked cycles", bad_cycles); else n_pass++;
    n_checks++; if (lane_err(0) !== 16'd8) $display("[TB] FAIL unlock_err_hold got %0d want 8", lane_err(0)); else n_pass++;
    inv0[0] = 1'b0;
  endtask

  task automatic test_stuck_lines();
    int bad_cycles;
    use_drv[2] = 1'b1;
    rx_drv[2]  = 1'b0;
    repeat (15) @(negedge clk);
    for (int v = 0; v < 2; v++) begin
      rx_drv[2] = v[0];
      bad_cycles = 0;
      repeat (1000) begin
        @(negedge clk);
        if (bus0.locked[2] !== 1'b0) bad_cycles++;
      end
      n_checks++;
      if (bad_cycles !== 0) $display("[TB] FAIL stuck_at_%0d got %0d want 0 locked cycles", v, bad_cycles); else n_pass++;
    end
    use_drv[2] = 1'b0;
  endtask

  task automatic test_loop_mode();
    logic r_hist [$];
    logic i_hist [$];
    logic exp_bit;
    int   bad_lock;
    bad_lock = 0;
    use_drv[1] = 1'b1;
    for (int j = 0; j < 200; j++) begin
      @(negedge clk);
      if (j >= 3) begin
        exp_bit = r_hist[j-3] ^ i_hist[j-1];
        n_checks++;
        if (bus0.tx_out[1] !== exp_bit)
          $display("[TB] FAIL loop_tx_%0d got %b want %b", j, bus0.tx_out[1], exp_bit);
        else n_pass++;
      end
      if (j >= 1 && (bus0.locked[1] !== 1'b0 || bus0.all_locked !== 1'b0)) bad_lock++;
      bus0.mode  = 3'b010;
      rx_drv[1]  = 1'($urandom_range(0, 1));
      bus0.inject = {1'b0, ($urandom_range(0, 3) == 0), 1'b0};
      r_hist.push_back(rx_drv[1]);
      i_hist.push_back(bus0.inject[1]);
    end
    n_checks++; if (bad_lock !== 0) $display("[TB] FAIL loop_locked got %0d want 0 locked cycles", bad_lock); else n_pass++;
    n_checks++;
    if (lane_err(1) !== 16'(3 * n_inject)) $display("[TB] FAIL loop_err_hold got %0d want %0d", lane_err(1), 3 * n_inject);
    else n_pass++;
    bus0.mode = 3'b000;
    bus0.inject = 3'b000;
    use_drv[1] = 1'b0;
  endtask

  task automatic test_counter_sat();
    bit reached;
    int wrong;
    reached = 1'b0;
    inv1 = 1'b1;
    for (int k = 0; k < 60 && !reached; k++) begin
      @(negedge clk);
      if (bus1.err_cnt === 4'd15) reached = 1'b1;
    end
    n_checks++; if (!reached) $display("[TB] FAIL sat_reach got %0d want 15", bus1.err_cnt); else n_pass++;
    wrong = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus1.err_cnt !== 4'd15) wrong++;
    end
    n_checks++; if (wrong !== 0) $display("[TB] FAIL sat_hold got %0d want 0 off-15 cycles", wrong); else n_pass++;
    bus1.err_clr = 1'b1;
    @(negedge clk);
    bus1.err_clr = 1'b0;
    n_checks++; if (bus1.err_cnt !== 4'd0) $display("[TB] FAIL clr_priority got %0d want 0", bus1.err_cnt); else n_pass++;
    n_checks++; if (bus1.locked !== 1'b1) $display("[TB] FAIL clr_keeps_lock got %b want 1", bus1.locked); else n_pass++;
    inv1 = 1'b0;
  endtask

  task automatic test_back_to_back();
    repeat (150) @(negedge clk);
    n_checks++; if (bus0.locked !== 3'b111) $display("[TB] FAIL relock got %b want 111", bus0.locked); else n_pass++;
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus0.tx_out !== 3'b000 || bus0.locked !== 3'b000 || bus0.all_locked !== 1'b0 || bus0.err_cnt !== 48'd0)
      $display("[TB] FAIL mid_lock_reset got tx=%b lk=%b al=%b err=%h want all 0",
               bus0.tx_out, bus0.locked, bus0.all_locked, bus0.err_cnt);
    else n_pass++;
    n_checks++; if (bus1.locked !== 1'b0) $display("[TB] FAIL dut1_reset got %b want 0", bus1.locked); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single_inject();
    test_unlock();
    test_stuck_lines();
    test_loop_mode();
    test_counter_sat();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
